// File: rtl/sdram_output_layer_if.sv
// Avalon-MM 16-bit master bus between sdram_output_layer and the SDRAM slave.
//   read_n/write_n     : active-low strobes (master -> slave)
//   chipselect         : held at 1 by the master
//   byteenable         : always 2'b11
//   address            : 32-bit word address
//   writedata          : signed write word
//   waitrequest        : slave stall (slave -> master)
//   readdatavalid      : read return strobe
//   readdata           : signed read word
interface sdram_output_layer_if;
  logic               read_n;
  logic               write_n;
  logic               chipselect;
  logic [1:0]         byteenable;
  logic [31:0]        address;
  logic signed [15:0] writedata;
  logic               waitrequest;
  logic               readdatavalid;
  logic signed [15:0] readdata;

  modport master (
    output read_n, write_n, chipselect, byteenable, address, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  read_n, write_n, chipselect, byteenable, address, writedata,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/sdram_output_layer.sv
// Output layer of the digit classifier. Reads back the binarized hidden-node
// sums and the class weight matrix over an Avalon-MM master, accumulates one
// score per class, selects the argmax and writes scores plus digit to SDRAM.
//   clk, reset : clock and asynchronous active-high reset
//   startSig   : level start request, sampled in IDLE
//   doneSig    : high while in DONE
//   bus        : Avalon-MM master port (see sdram_output_layer_if)
//   digit      : winning class, held until overwritten by the next run
//   s          : current state code
module sdram_output_layer #(
  parameter int unsigned HID_BASE = 158000,
  parameter int unsigned N_HID    = 200,
  parameter int unsigned W_BASE   = 158200,
  parameter int unsigned N_OUT    = 10,
  parameter int unsigned RES_ADDR = 160200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startSig,
  output logic                 doneSig,
  sdram_output_layer_if.master bus,
  output logic [3:0]           digit,
  output logic [3:0]           s
);

  localparam int unsigned N_RD = N_HID * (N_OUT + 1);
  localparam int unsigned RW   = $clog2(N_RD + 1);
  localparam int unsigned JW   = $clog2(N_HID);
  localparam int unsigned KW   = $clog2(N_OUT);
  localparam int unsigned WW   = $clog2(N_OUT + 1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    READ   = 4'd1,
    DRAIN  = 4'd2,
    ARGMAX = 4'd3,
    WRITE  = 4'd4,
    DONE   = 4'd5
  } state_t;

  state_t             state;
  logic [RW-1:0]      iss;        // issue index
  logic [RW-1:0]      ret;        // return index
  logic [JW-1:0]      j;          // column within current row of returns
  logic [KW-1:0]      k;          // class row of returns
  logic               wt_phase;   // returns past the hidden sums
  logic [N_HID-1:0]   act;
  logic signed [23:0] score [N_OUT];
  logic [KW-1:0]      ak;
  logic [KW-1:0]      best_idx;
  logic signed [23:0] best;
  logic [WW-1:0]      wi;

  logic [RW-1:0]      iss_nxt;
  logic [31:0]        rd_addr_nxt;
  logic [WW-1:0]      wi_nxt;
  logic signed [15:0] wr_data_nxt;
  logic signed [23:0] rd_ext;

  function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
    if (v > 24'sd32767)
      return 16'sh7FFF;
    else if (v < -24'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  assign iss_nxt     = iss + 1'b1;
  assign rd_addr_nxt = (iss_nxt < RW'(N_HID)) ? 32'(HID_BASE) + 32'(iss_nxt)
                                              : 32'(W_BASE) + 32'(iss_nxt) - 32'(N_HID);
  assign wi_nxt      = wi + 1'b1;
  assign wr_data_nxt = (wi_nxt < WW'(N_OUT)) ? sat16(score[KW'(wi_nxt)]) : 16'(digit);
  assign rd_ext      = 24'(bus.readdata);

  assign bus.chipselect = 1'b1;
  assign bus.byteenable = 2'b11;
  assign s              = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      doneSig       <= 1'b0;
      bus.read_n    <= 1'b1;
      bus.write_n   <= 1'b1;
      bus.address   <= '0;
      bus.writedata <= '0;
      digit         <= '0;
      iss           <= '0;
      ret           <= '0;
      j             <= '0;
      k             <= '0;
      wt_phase      <= 1'b0;
      act           <= '0;
      ak            <= '0;
      best_idx      <= '0;
      best          <= '0;
      wi            <= '0;
      for (int unsigned m = 0; m < N_OUT; m++) score[m] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startSig) begin
            iss         <= '0;
            ret         <= '0;
            j           <= '0;
            k           <= '0;
            wt_phase    <= 1'b0;
            act         <= '0;
            for (int unsigned m = 0; m < N_OUT; m++) score[m] <= '0;
            bus.read_n  <= 1'b0;
            bus.address <= 32'(HID_BASE);
            state       <= READ;
          end
        end

        READ: begin
          if (!bus.read_n && !bus.waitrequest) begin
            if (iss == RW'(N_RD - 1)) begin
              bus.read_n <= 1'b1;
              state      <= DRAIN;
            end else begin
              iss         <= iss_nxt;
              bus.address <= rd_addr_nxt;
            end
          end
        end

        DRAIN: begin
          // ret already includes every return accumulated up to this edge.
          if (ret == RW'(N_RD)) begin
            ak    <= '0;
            state <= ARGMAX;
          end
        end

        ARGMAX: begin
          // best holds the maximum of score[0..ak-1]; strict compare keeps
          // the lowest index on ties.
          if (ak == '0) begin
            best     <= score[0];
            best_idx <= '0;
          end else if (score[ak] > best) begin
            best     <= score[ak];
            best_idx <= ak;
          end
          if (ak == KW'(N_OUT - 1)) begin
            digit         <= (score[ak] > best) ? 4'(ak) : 4'(best_idx);
            wi            <= '0;
            bus.write_n   <= 1'b0;
            bus.address   <= 32'(RES_ADDR);
            bus.writedata <= sat16(score[0]);
            state         <= WRITE;
          end else begin
            ak <= ak + 1'b1;
          end
        end

        WRITE: begin
          if (!bus.write_n && !bus.waitrequest) begin
            if (wi == WW'(N_OUT)) begin
              bus.write_n <= 1'b1;
              doneSig     <= 1'b1;
              state       <= DONE;
            end else begin
              wi            <= wi_nxt;
              bus.address   <= 32'(RES_ADDR) + 32'(wi_nxt);
              bus.writedata <= wr_data_nxt;
            end
          end
        end

        DONE: begin
          if (!startSig) begin
            doneSig <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Return path runs independently of issue; j/k walk the row-major
      // layout so no divide is needed.
      if ((state == READ || state == DRAIN) && bus.readdatavalid) begin
        if (!wt_phase)
          act[j] <= (bus.readdata > 16'sd0);
        else if (act[j])
          score[k] <= score[k] + rd_ext;
        ret <= ret + 1'b1;
        if (j == JW'(N_HID - 1)) begin
          j        <= '0;
          wt_phase <= 1'b1;
          if (wt_phase) k <= k + 1'b1;
        end else begin
          j <= j + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/sdram_output_layer.md
# sdram_output_layer

Second-layer inference stage placed directly downstream of the hidden-layer SDRAM master. It runs after that stage has written its 200 signed 16-bit hidden-node sums to SDRAM. Over the same 16-bit Avalon-MM master interface, the block reads the sums back and binarizes them (value > 0 gives 1). It then streams in a 10×200 weight matrix, accumulates one score per class, picks the argmax, and writes the 10 scores plus the winning digit back to SDRAM.

## Interface
- HID_BASE, 158000: word address of the first hidden-node sum.
- N_HID, 200: number of hidden nodes.
- W_BASE, 158200: word address of weight w[0][0]; row-major, w[k][j] at W_BASE + k*N_HID + j.
- N_OUT, 10: number of output classes.
- RES_ADDR, 160200: scores written to RES_ADDR..RES_ADDR+N_OUT-1; digit written to RES_ADDR+N_OUT.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- startSig  in  1  level start request.
- doneSig  out  1  high in DONE.
- read_n, write_n  out  1  Avalon read/write strobes, active-low.
- chipselect  out  1  constant 1 after reset.
- byteenable  out  2  constant 2'b11.
- address  out  32  word address.
- waitrequest  in  1  slave stall.
- readdatavalid  in  1  read return strobe.
- readdata  in  16  signed return data.
- writedata  out  16  signed write data.
- digit  out  4  argmax result, held until next start.
- s  out  4  current state code.

## Operation
- Reset values: state IDLE (s=0), doneSig=0, read_n=1, write_n=1, chipselect=1, byteenable=2'b11, address=0, writedata=0, digit=0. All counters, scores and activation bits are cleared.
- State codes: IDLE=0, READ=1, DRAIN=2, ARGMAX=3, WRITE=4, DONE=5.
- IDLE: on startSig=1, clear issue counter, return counter, the 10 scores and the 200 activation bits, then go to READ.
- READ: issue N_HID + N_OUT*N_HID = 2200 reads.
  - For issue index i < N_HID, address = HID_BASE+i.
  - For all other i, address = W_BASE+(i−N_HID).
  - A read is accepted on a cycle with read_n=0 and waitrequest=0. Only then do i and address advance; otherwise address and read_n are held.
  - After the last read is accepted, read_n=1 and the block goes to DRAIN.
- Return path: runs independently of issue and counts readdatavalid pulses with return index r.
  - r < N_HID: act[r] = (readdata > 0).
  - Otherwise, with k = (r−N_HID)/N_HID and j = (r−N_HID) mod N_HID: if act[j], then score[k] += sign-extended readdata.
  - score registers are 24-bit signed; no overflow is possible at these sizes.
  - k and j are tracked with counters, not divide/mod.
  - readdatavalid is ignored outside READ and DRAIN.
- DRAIN: wait until r = 2200, then go to ARGMAX.
- ARGMAX: one compare per cycle over k = 0..9, taking a strictly-greater winner. Ties resolve to the lowest index. digit is updated on the last compare, then the block goes to WRITE.
- WRITE: 11 writes.
  - Word m < 10: saturated score[m], clamped to [−32768, 32767], at RES_ADDR+m.
  - Word 10: zero-extended digit, at RES_ADDR+10.
  - Same acceptance rule as READ, using write_n. address and writedata are held while stalled.
  - After the 11th write is accepted, write_n=1 and the block goes to DONE.
- DONE: doneSig=1. When startSig=0, go to IDLE with doneSig=0.
- startSig changes outside IDLE and DONE are ignored.
- reset asserted in any state aborts immediately: no further strobes, and partial results are discarded.

## Timing
- IDLE→READ: 1 cycle after startSig sampled high. First read_n=0 in the READ cycle.
- With waitrequest≡0, one read is accepted per cycle: READ lasts 2200 cycles.
- DRAIN lasts until the last readdatavalid, plus 1 cycle.
- ARGMAX lasts 10 cycles.
- WRITE lasts 11 cycles with no stalls.
- read_n and write_n are never low in the same cycle.
- Accumulation takes effect in the cycle after each readdatavalid.
- If the last readdatavalid coincides with the DRAIN exit check, it is still accumulated before ARGMAX reads the scores.

## Test plan
- Ideal slave, 2-cycle read latency. Hidden sums all +5; weights all 1 except row 3 all 2. Required: scores 200 (rows ≠3) and 400 (row 3), digit=3 at RES_ADDR+10, doneSig=1.
- Hidden sums alternate 0, −7. Required: all acts 0, all scores 0, digit=0 (tie to lowest).
- Hidden sums all 1; row 7 weights all 32767, others 1. Required: internal score[7]=6553400, written value 32767, others 200, digit=7.
- Same data as the first test, with waitrequest randomly high 50% and read latency 1–8 cycles. Required: identical SDRAM results, and address/read_n/write_n/writedata stable across every stall cycle.
- Rows 2 and 5 produce equal maximum score 150. Required: digit=2.
- reset pulsed at issue index 500. Required: all outputs at reset values in that cycle, no write to RES_ADDR. A new start then produces the same results as the first test.
